ksa: RTL and testbench

Key-scheduling engine for the ARC4 datapath. It runs the ARC4 key-scheduling pass in place over the 256×8 S memory that the init stage has already filled with s[i]=i. It is the read-modify-write counterpart to that write-only stage: for each i it reads s[i] and s[j], then writes both back swapped. It sits between init and the PRGA stage and shares the single-port S memory with them through the top-level mux.

---
 rtl/ksa_pkg.sv | 33 +++
 rtl/ksa.sv | 111 +++++++++++
 tb/tb_ksa.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_pkg.sv
// Shared types and constants for the ARC4 key-scheduling engine.
// Holds the FSM state encoding and key-byte selection helper.
package ksa_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int KEY_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LT_I,
        RD_J,
        LT_J,
        WR_I,
        WR_J
    } state_t;

    // Key bytes are consumed most-significant first.
    function automatic logic [7:0] key_byte(
        input logic [23:0] k,
        input logic [1:0]  kidx
    );
        logic [7:0] kb;
        unique case (kidx)
            2'd0:    kb = k[23:16];
            2'd1:    kb = k[15:8];
            default: kb = k[7:0];
        endcase
        return kb;
    endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling pass over the shared 256x8 S memory.
// Six-cycle read/read/write/write loop per index, single-port memory.
module ksa
    import ksa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    localparam logic [AW-1:0] LAST_I = AW'(MEM_DEPTH - 1);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [1:0]    kidx;
    logic [23:0]   key_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            kidx  <= '0;
            key_r <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        key_r <= key;
                        i     <= '0;
                        j     <= '0;
                        kidx  <= '0;
                    end
                end
                LT_I: begin
                    si <= rddata;
                    j  <= j + rddata + key_byte(key_r, kidx);
                end
                LT_J: begin
                    sj <= rddata;
                end
                WR_J: begin
                    if (i != LAST_I) begin
                        i <= i + AW'(1);
                        // mod-3 key index tracks i without a divider
                        kidx <= (kidx == 2'(KEY_BYTES - 1))
                              ? 2'd0 : kidx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        rdy     = 1'b0;
        wren    = 1'b0;
        addr    = '0;
        wrdata  = '0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_n = RD_I;
            end
            RD_I: begin
                addr    = i;
                state_n = LT_I;
            end
            LT_I: begin
                addr    = i;
                state_n = RD_J;
            end
            RD_J: begin
                addr    = j;
                state_n = LT_J;
            end
            LT_J: begin
                addr    = j;
                state_n = WR_I;
            end
            WR_I: begin
                addr    = i;
                wrdata  = sj;
                wren    = 1'b1;
                state_n = WR_J;
            end
            WR_J: begin
                addr    = j;
                wrdata  = si;
                wren    = 1'b1;
                state_n = (i == LAST_I) ? IDLE : RD_I;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: behavioural ARC4 KSA model,
// single-port memory model and write log.
module tb_ksa;
    import ksa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] key;
    logic        rdy;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    logic [7:0]  mem   [256];
    logic [7:0]  ref_s [256];
    logic [7:0]  wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  ra[$];
    logic [7:0]  rd[$];

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ksa dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    // Single-port S memory with one cycle read latency.
    always @(posedge clk) begin
        rddata <= mem[addr];
        if (wren) begin
            mem[addr] = wrdata;
            wa.push_back(addr);
            wd.push_back(wrdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Textbook ARC4 KSA on ref_s, logging the swap writes.
    function automatic void model(input logic [23:0] k);
        logic [7:0] jj;
        logic [7:0] t;
        logic [7:0] kb;
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            case (n % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            jj = jj + ref_s[n] + kb;
            t  = ref_s[n];
            ra.push_back(8'(n));
            rd.push_back(ref_s[jj]);
            ra.push_back(jj);
            rd.push_back(t);
            ref_s[n]  = ref_s[jj];
            ref_s[jj] = t;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_identity();
        for (int k = 0; k < 256; k++) begin
            mem[k]   = 8'(k);
            ref_s[k] = 8'(k);
        end
        wa.delete();
        wd.delete();
        ra.delete();
        rd.delete();
    endtask

    task automatic start(input logic [23:0] k);
        en  = 1'b1;
        key = k;
        tick(1);
        en  = 1'b0;
    endtask

    task automatic wait_done(output int lo);
        lo = 0;
        while (!rdy && lo < 4000) begin
            lo++;
            tick(1);
        end
        if (lo >= 4000) chk("timeout", 1, 0);
    endtask

    task automatic cmp_mem(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (mem[k] !== ref_s[k]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic cmp_writes(input string tag);
        int bad;
        int n;
        bad = 0;
        n = (wa.size() < ra.size()) ? wa.size() : ra.size();
        chk({tag, "_cnt"}, wa.size(), ra.size());
        for (int k = 0; k < n; k++)
            if (wa[k] !== ra[k] || wd[k] !== rd[k]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic chk_wr(input string tag, input int idx,
                          input logic [15:0] exp);
        if (idx < wa.size())
            chk(tag, {wa[idx], wd[idx]}, exp);
        else
            chk(tag, 32'hdead, exp);
    endtask

    initial begin
        int lo;
        int n;
        logic [23:0] k;
        rst_n = 1'b0;
        en    = 1'b0;
        key   = '0;
        load_identity();

        // Reset and idle
        tick(2);
        rst_n = 1'b1;
        chk("rst_rdy", rdy, 1);
        chk("rst_wren", wren, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wrdata", wrdata, 0);
        tick(10);
        chk("rst_nowr", wa.size(), 0);
        chk("idle_rdy", rdy, 1);

        // First swaps
        load_identity();
        model(24'h010203);
        start(24'h010203);
        chk("busy_after_en", rdy, 0);
        wait_done(lo);
        chk("len_010203", lo, 1536);
        chk_wr("fs_w0", 0, 16'h0001);
        chk_wr("fs_w1", 1, 16'h0100);
        chk_wr("fs_w2", 2, 16'h0103);
        chk_wr("fs_w3", 3, 16'h0300);
        cmp_writes("wr_010203");
        cmp_mem("mem_010203");

        // Self-swap with an all-zero key
        load_identity();
        model(24'h000000);
        start(24'h000000);
        wait_done(lo);
        chk_wr("ss_w0", 0, 16'h0000);
        chk_wr("ss_w1", 1, 16'h0000);
        chk_wr("ss_w2", 2, 16'h0101);
        chk_wr("ss_w3", 3, 16'h0101);
        chk_wr("ss_w4", 4, 16'h0203);
        chk_wr("ss_w5", 5, 16'h0302);
        cmp_mem("mem_000000");

        // Full run
        load_identity();
        model(24'h00033C);
        start(24'h00033C);
        wait_done(lo);
        chk("len_00033c", lo, 1536);
        chk("wren_cnt", wa.size(), 512);
        cmp_mem("mem_00033c");

        // en while busy is ignored
        load_identity();
        model(24'h00033C);
        start(24'h00033C);
        tick(99);
        en  = 1'b1;
        key = 24'hABCDEF;
        tick(1);
        en  = 1'b0;
        chk("busy_rdy", rdy, 0);
        wait_done(lo);
        cmp_mem("mem_busy");

        // Mid-run reset
        load_identity();
        start(24'h123456);
        tick(699);
        rst_n = 1'b0;
        tick(1);
        chk("mr_rdy", rdy, 1);
        chk("mr_wren", wren, 0);
        rst_n = 1'b1;
        n = wa.size();
        tick(20);
        chk("mr_nowr", wa.size(), n);
        chk("mr_idle", rdy, 1);

        // Back-to-back with en held high
        load_identity();
        model(24'h5A5A01);
        model(24'h5A5A01);
        en  = 1'b1;
        key = 24'h5A5A01;
        tick(1);
        wait_done(lo);
        chk("b2b_len", lo, 1536);
        chk("b2b_rdy_hi", rdy, 1);
        tick(1);
        chk("b2b_rdy_lo", rdy, 0);
        chk("b2b_addr", addr, 0);
        en = 1'b0;
        wait_done(lo);
        cmp_mem("mem_b2b");

        // Random keys
        for (int r = 0; r < 4; r++) begin
            k = 24'($urandom);
            load_identity();
            model(k);
            start(k);
            wait_done(lo);
            chk("rnd_len", lo, 1536);
            cmp_writes("rnd_wr");
            cmp_mem("rnd_mem");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
